// File: rtl/dma_pcie_mi_ram_pkg.sv
// Shared constants, init-state encoding and byte-parity helper for the 64B x 128 MI RAM.
// Pure declarations: no latency, no flow control.
package dma_pcie_mi_ram_pkg;

   localparam int MI_RAM_DEPTH   = 128;
   localparam int MI_RAM_AW      = 7;
   localparam int MI_RAM_DW      = 512;
   localparam int MI_RAM_PW      = 64;
   localparam int MI_RAM_HALF_DW = 256;

   typedef enum logic [1:0] {
      MI_RAM_IDLE  = 2'd0,
      MI_RAM_CLEAR = 2'd1,
      MI_RAM_DONE  = 2'd2
   } mi_ram_init_e;

   // Even parity per byte: bit i is the XOR of data byte i.
   function automatic logic [MI_RAM_PW-1:0] byte_par(input logic [MI_RAM_DW-1:0] d);
      logic [MI_RAM_PW-1:0] p;
      for (int i = 0; i < MI_RAM_PW; i++) begin
         p[i] = ^d[8*i +: 8];
      end
      return p;
   endfunction

endpackage

// File: rtl/dma_pcie_mi_64Bx128_32Bwe_ram_if.sv
// MI RAM link: 512-bit words, per-byte parity, two 32-byte write enables.
// Wires only: no latency, no flow control (reads are fire-and-forget).
interface dma_pcie_mi_64Bx128_32Bwe_ram_if;
   import dma_pcie_mi_ram_pkg::*;

   logic [MI_RAM_AW-1:0] wadr;
   logic [1:0]           wen;
   logic [MI_RAM_PW-1:0] wpar;
   logic [MI_RAM_DW-1:0] wdat;
   logic                 ren;
   logic [MI_RAM_AW-1:0] radr;
   logic [MI_RAM_PW-1:0] rpar;
   logic [MI_RAM_DW-1:0] rdat;
   logic                 rsbe;
   logic                 rdbe;

   modport m (output wadr, wen, wpar, wdat, ren, radr,
              input  rpar, rdat, rsbe, rdbe);
   modport s (input  wadr, wen, wpar, wdat, ren, radr,
              output rpar, rdat, rsbe, rdbe);

endinterface

// File: rtl/dma_pcie_mi_ram_par_chk.sv
// Per-byte parity check of a 512-bit word; flags one bad byte (sbe) or two-plus (dbe).
// Combinational, no backpressure.
module dma_pcie_mi_ram_par_chk
   import dma_pcie_mi_ram_pkg::*;
(
   input  logic [MI_RAM_DW-1:0] dat,
   input  logic [MI_RAM_PW-1:0] par,
   output logic                 sbe,
   output logic                 dbe
);

   logic [MI_RAM_PW-1:0] mis;
   logic [1:0]           cnt;

   // Count saturates at 2: only "one" versus "more than one" matters.
   always_comb begin
      mis = byte_par(dat) ^ par;
      cnt = 2'd0;
      for (int i = 0; i < MI_RAM_PW; i++) begin
         if (mis[i] && (cnt != 2'd2)) begin
            cnt = cnt + 2'd1;
         end
      end
      sbe = (cnt == 2'd1);
      dbe = (cnt == 2'd2);
   end

endmodule

// File: rtl/dma_pcie_mi_64bx128_ram_rsp.sv
// MI RAM responder: 128 x 512b + parity, self-clearing; read error injection under DMA_PCIE_MI_RAM_ERRINJ_EN.
// Read latency RD_LAT (1 or 2) cycles, one read per cycle; no backpressure, accesses ignored until init_done.
module dma_pcie_mi_64bx128_ram_rsp
   import dma_pcie_mi_ram_pkg::*;
#(
   parameter int RD_LAT = 2
)(
   input  logic                       clk,
   input  logic                       rst,
   dma_pcie_mi_64Bx128_32Bwe_ram_if.s ram,
   output logic                       init_done
`ifdef DMA_PCIE_MI_RAM_ERRINJ_EN
   ,
   input  logic                       inj_sbe,
   input  logic                       inj_dbe
`endif
);

   mi_ram_init_e         state, state_nxt;
   logic [MI_RAM_AW-1:0] clr_adr, clr_adr_nxt;

   always_ff @(posedge clk) begin
      if (rst) begin
         state   <= MI_RAM_CLEAR;
         clr_adr <= '0;
      end else begin
         state   <= state_nxt;
         clr_adr <= clr_adr_nxt;
      end
   end

   always_comb begin
      state_nxt   = state;
      clr_adr_nxt = clr_adr;
      case (state)
         MI_RAM_IDLE: begin
            state_nxt   = MI_RAM_CLEAR;
            clr_adr_nxt = '0;
         end
         MI_RAM_CLEAR: begin
            clr_adr_nxt = clr_adr + MI_RAM_AW'(1);
            if (clr_adr == MI_RAM_AW'(MI_RAM_DEPTH - 1)) begin
               state_nxt = MI_RAM_DONE;
            end
         end
         default: begin
         end
      endcase
   end

   assign init_done = (state == MI_RAM_DONE);

   logic [MI_RAM_HALF_DW-1:0] mem_lo [MI_RAM_DEPTH];
   logic [MI_RAM_HALF_DW-1:0] mem_hi [MI_RAM_DEPTH];
   logic [MI_RAM_PW/2-1:0]    par_lo [MI_RAM_DEPTH];
   logic [MI_RAM_PW/2-1:0]    par_hi [MI_RAM_DEPTH];

   always_ff @(posedge clk) begin
      if (state == MI_RAM_CLEAR) begin
         mem_lo[clr_adr] <= '0;
         mem_hi[clr_adr] <= '0;
         par_lo[clr_adr] <= '0;
         par_hi[clr_adr] <= '0;
      end else if (init_done && !rst) begin
         if (ram.wen[0]) begin
            mem_lo[ram.wadr] <= ram.wdat[MI_RAM_HALF_DW-1:0];
            par_lo[ram.wadr] <= ram.wpar[MI_RAM_PW/2-1:0];
         end
         if (ram.wen[1]) begin
            mem_hi[ram.wadr] <= ram.wdat[MI_RAM_DW-1:MI_RAM_HALF_DW];
            par_hi[ram.wadr] <= ram.wpar[MI_RAM_PW-1:MI_RAM_PW/2];
         end
      end
   end

   logic [MI_RAM_DW-1:0] arr_dat, rd_dat;
   logic [MI_RAM_PW-1:0] arr_par, rd_par;

   assign arr_dat = {mem_hi[ram.radr], mem_lo[ram.radr]};
   assign arr_par = {par_hi[ram.radr], par_lo[ram.radr]};

   // Until the clear is complete the array is not trusted: reads return all-zero.
`ifdef DMA_PCIE_MI_RAM_ERRINJ_EN
   logic [MI_RAM_DW-1:0] inj_mask;

   always_comb begin
      inj_mask = '0;
      if (inj_dbe) begin
         inj_mask[0] = 1'b1;
         inj_mask[8] = 1'b1;
      end else if (inj_sbe) begin
         inj_mask[0] = 1'b1;
      end
   end

   assign rd_dat = init_done ? (arr_dat ^ inj_mask) : '0;
`else
   assign rd_dat = init_done ? arr_dat : '0;
`endif
   assign rd_par = init_done ? arr_par : '0;

   logic                 s_vld;
   logic [MI_RAM_DW-1:0] s_dat;
   logic [MI_RAM_PW-1:0] s_par;

   generate
      if (RD_LAT == 2) begin : g_lat2
         always_ff @(posedge clk) begin
            if (rst) begin
               s_vld <= 1'b0;
            end else begin
               s_vld <= ram.ren;
            end
            if (ram.ren) begin
               s_dat <= rd_dat;
               s_par <= rd_par;
            end
         end
      end else begin : g_lat1
         assign s_vld = ram.ren;
         assign s_dat = rd_dat;
         assign s_par = rd_par;
      end
   endgenerate

   logic chk_sbe, chk_dbe;

   dma_pcie_mi_ram_par_chk u_par_chk (
      .dat (s_dat),
      .par (s_par),
      .sbe (chk_sbe),
      .dbe (chk_dbe)
   );

   logic [MI_RAM_DW-1:0] rdat_q;
   logic [MI_RAM_PW-1:0] rpar_q;
   logic                 rsbe_q, rdbe_q;

   // Data holds between reads; flags are single-cycle pulses.
   always_ff @(posedge clk) begin
      if (rst) begin
         rdat_q <= '0;
         rpar_q <= '0;
         rsbe_q <= 1'b0;
         rdbe_q <= 1'b0;
      end else begin
         rsbe_q <= s_vld & chk_sbe;
         rdbe_q <= s_vld & chk_dbe;
         if (s_vld) begin
            rdat_q <= s_dat;
            rpar_q <= s_par;
         end
      end
   end

   assign ram.rdat = rdat_q;
   assign ram.rpar = rpar_q;
   assign ram.rsbe = rsbe_q;
   assign ram.rdbe = rdbe_q;

endmodule

// File: tb/tb_dma_pcie_mi_64bx128_ram_rsp.sv
// Bench for the MI RAM responder: directed scenarios plus random traffic against a queue-based model.
`timescale 1ns/1ps
module tb_dma_pcie_mi_64bx128_ram_rsp;

   localparam int RD_LAT = 2;

   logic clk = 1'b0;
   logic rst;
   logic init_done;
   logic inj_sbe, inj_dbe;

   dma_pcie_mi_64Bx128_32Bwe_ram_if ram_if ();

   dma_pcie_mi_64bx128_ram_rsp #(.RD_LAT(RD_LAT)) dut (
      .clk       (clk),
      .rst       (rst),
      .ram       (ram_if),
      .init_done (init_done)
`ifdef DMA_PCIE_MI_RAM_ERRINJ_EN
      ,
      .inj_sbe   (inj_sbe),
      .inj_dbe   (inj_dbe)
`endif
   );

   always #5 clk = ~clk;

   typedef struct {
      int           due;
      logic [511:0] dat;
      logic [63:0]  par;
      logic         sbe;
      logic         dbe;
   } rd_t;

   rd_t          pend[$];
   logic [511:0] m_dat [128];
   logic [63:0]  m_par [128];
   logic [511:0] e_rdat;
   logic [63:0]  e_rpar;
   logic         e_sbe, e_dbe;
   int           clr_cnt, edge_n, n_chk, n_err;

   task automatic chk(input string tag, input logic [511:0] act, input logic [511:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h (edge %0d)", tag, act, exp, edge_n);
      end
   endtask

   function automatic logic [63:0] good_par(input logic [511:0] d);
      logic [63:0] p;
      for (int i = 0; i < 64; i++) p[i] = ^d[8*i +: 8];
      return p;
   endfunction

   function automatic int bad_bytes(input logic [511:0] d, input logic [63:0] p);
      int n;
      n = 0;
      for (int i = 0; i < 64; i++) if ((^d[8*i +: 8]) != p[i]) n++;
      return n;
   endfunction

   function automatic logic [511:0] rnd512();
      logic [511:0] r;
      for (int i = 0; i < 16; i++) r[32*i +: 32] = $urandom;
      return r;
   endfunction

   task automatic idle();
      ram_if.ren  = 1'b0;
      ram_if.radr = '0;
      ram_if.wen  = 2'b00;
      ram_if.wadr = '0;
      ram_if.wdat = '0;
      ram_if.wpar = '0;
      inj_sbe     = 1'b0;
      inj_dbe     = 1'b0;
   endtask

   // One clock: model the inputs currently applied, advance, then compare all outputs.
   task automatic step();
      rd_t r;
      int  nb;
      bit  done_pre;
      done_pre = (clr_cnt >= 128);
      if (!rst) begin
         if (ram_if.ren) begin
            r.due = edge_n + RD_LAT;
            if (done_pre) begin
               r.dat = m_dat[ram_if.radr];
               r.par = m_par[ram_if.radr];
               if (inj_dbe) begin
                  r.dat[0] = ~r.dat[0];
                  r.dat[8] = ~r.dat[8];
               end else if (inj_sbe) begin
                  r.dat[0] = ~r.dat[0];
               end
            end else begin
               r.dat = '0;
               r.par = '0;
            end
            nb    = bad_bytes(r.dat, r.par);
            r.sbe = (nb == 1);
            r.dbe = (nb >= 2);
            pend.push_back(r);
         end
         if (done_pre) begin
            if (ram_if.wen[0]) begin
               m_dat[ram_if.wadr][255:0] = ram_if.wdat[255:0];
               m_par[ram_if.wadr][31:0]  = ram_if.wpar[31:0];
            end
            if (ram_if.wen[1]) begin
               m_dat[ram_if.wadr][511:256] = ram_if.wdat[511:256];
               m_par[ram_if.wadr][63:32]   = ram_if.wpar[63:32];
            end
         end
      end
      @(posedge clk);
      edge_n++;
      e_sbe = 1'b0;
      e_dbe = 1'b0;
      if (rst) begin
         clr_cnt = 0;
         pend.delete();
         e_rdat = '0;
         e_rpar = '0;
         for (int i = 0; i < 128; i++) begin
            m_dat[i] = '0;
            m_par[i] = '0;
         end
      end else begin
         clr_cnt++;
         if (pend.size() > 0 && pend[0].due == edge_n) begin
            r      = pend.pop_front();
            e_rdat = r.dat;
            e_rpar = r.par;
            e_sbe  = r.sbe;
            e_dbe  = r.dbe;
         end
      end
      #1;
      chk("init_done", 512'(init_done), 512'(clr_cnt >= 128));
      chk("rdat", ram_if.rdat, e_rdat);
      chk("rpar", 512'(ram_if.rpar), 512'(e_rpar));
      chk("rsbe", 512'(ram_if.rsbe), 512'(e_sbe));
      chk("rdbe", 512'(ram_if.rdbe), 512'(e_dbe));
   endtask

   task automatic wr(input logic [6:0] a, input logic [1:0] we, input logic [511:0] d, input logic [63:0] p);
      idle();
      ram_if.wen  = we;
      ram_if.wadr = a;
      ram_if.wdat = d;
      ram_if.wpar = p;
      step();
   endtask

   task automatic rd(input logic [6:0] a);
      idle();
      ram_if.ren  = 1'b1;
      ram_if.radr = a;
      step();
   endtask

   task automatic drain();
      idle();
      repeat (RD_LAT + 1) step();
   endtask

   initial begin
      logic [511:0] d;
      logic [63:0]  p;
      int           k, b1, b2, b3;

      n_chk = 0; n_err = 0; edge_n = 0; clr_cnt = 0;
      e_rdat = '0; e_rpar = '0; e_sbe = 1'b0; e_dbe = 1'b0;
      rst = 1'b1;
      idle();
      repeat (3) step();
      rst = 1'b0;

      // Clear phase: early read returns zero, early write is dropped.
      while (clr_cnt < 130) begin
         idle();
         if (clr_cnt == 10) begin
            ram_if.ren  = 1'b1;
            ram_if.radr = 7'd5;
         end
         if (clr_cnt == 50) begin
            ram_if.wen  = 2'b11;
            ram_if.wadr = 7'd5;
            ram_if.wdat = rnd512();
            ram_if.wpar = good_par(ram_if.wdat);
         end
         step();
      end
      rd(7'd5);
      drain();

      wr(7'd3, 2'b11, {64{8'hA5}}, good_par({64{8'hA5}}));
      rd(7'd3);
      drain();

      wr(7'd7, 2'b01, {512{1'b1}}, 64'd0);
      rd(7'd7);
      drain();

      d = rnd512();
      wr(7'd9, 2'b11, d, good_par(d) ^ (64'd1 << 4));
      rd(7'd9);
      drain();
      wr(7'd9, 2'b11, d, good_par(d) ^ ((64'd1 << 4) | (64'd1 << 60)));
      rd(7'd9);
      drain();

      // Same-cycle write and read of one address is read-first.
      wr(7'd2, 2'b11, {64{8'h11}}, 64'd0);
      idle();
      ram_if.wen  = 2'b11;
      ram_if.wadr = 7'd2;
      ram_if.wdat = {64{8'h22}};
      ram_if.wpar = 64'd0;
      ram_if.ren  = 1'b1;
      ram_if.radr = 7'd2;
      step();
      rd(7'd2);
      drain();

`ifdef DMA_PCIE_MI_RAM_ERRINJ_EN
      idle(); ram_if.ren = 1'b1; ram_if.radr = 7'd3; inj_sbe = 1'b1; step();
      idle(); ram_if.ren = 1'b1; ram_if.radr = 7'd3; inj_dbe = 1'b1; step();
      idle(); ram_if.ren = 1'b1; ram_if.radr = 7'd3; inj_sbe = 1'b1; inj_dbe = 1'b1; step();
      rd(7'd3);
      drain();
`endif

      // Random traffic over a small address window to force collisions.
      for (int n = 0; n < 600; n++) begin
         idle();
         d  = rnd512();
         p  = good_par(d);
         k  = $urandom_range(0, 7);
         b1 = $urandom_range(0, 63);
         b2 = (b1 + 1 + $urandom_range(0, 61)) % 64;
         b3 = (b2 + 1 + $urandom_range(0, 61)) % 64;
         if (k <= 2) p[b1] = ~p[b1];
         if (k == 1 || k == 2) p[b2] = ~p[b2];
         if (k == 2 && b3 != b1) p[b3] = ~p[b3];
         ram_if.wen  = 2'($urandom_range(0, 3));
         ram_if.wadr = 7'($urandom_range(0, 15));
         ram_if.wdat = d;
         ram_if.wpar = p;
         ram_if.ren  = 1'($urandom_range(0, 1));
         ram_if.radr = 7'($urandom_range(0, 15));
`ifdef DMA_PCIE_MI_RAM_ERRINJ_EN
         inj_sbe = ($urandom_range(0, 5) == 0);
         inj_dbe = ($urandom_range(0, 5) == 0);
`endif
         step();
      end
      drain();

      // Reset while DONE restarts the clear and wipes the contents.
      rst = 1'b1;
      idle();
      repeat (2) step();
      rst = 1'b0;
      while (clr_cnt < 132) begin
         idle();
         if (clr_cnt == 20 || clr_cnt == 130) begin
            ram_if.ren  = 1'b1;
            ram_if.radr = 7'd3;
         end
         step();
      end
      drain();

      $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
      $finish;
   end

endmodule
